// File: rtl/sha2_msg_pack.sv
// sha2_msg_pack: producer side of the SHA-2 message FIFO.
// Compacts strobed register-bus bytes MSB-first into full words, emits one
// left-aligned partial word at end of message and tracks the length in bits.
module sha2_msg_pack #(
    parameter int MsgLenW = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               hash_start,
    input  logic               hash_process,
    input  logic               wr_valid,
    input  logic [31:0]        wr_data,
    input  logic [3:0]         wr_mask,
    output logic               wr_ready,
    output logic               fifo_wvalid,
    output logic [31:0]        fifo_wdata,
    output logic [3:0]         fifo_wmask,
    input  logic               fifo_wready,
    output logic [MsgLenW-1:0] message_length,
    output logic               msg_done
);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StFlush,
        StDone
    } state_e;

    state_e st, st_next;

    logic [1:0]         hold_cnt;
    logic [23:0]        hold_data;
    logic [1:0]         hold_cnt_next;
    logic [23:0]        hold_data_next;
    logic               out_free;
    logic               accept;
    logic               load_full;
    logic               load_part;
    logic               msg_done_next;
    logic [7:0]         bytes [7];
    logic [2:0]         pos;
    logic [2:0]         n;
    logic [2:0]         over;
    logic [MsgLenW-1:0] len_inc;
    logic [3:0]         part_mask;

    // The output register can take a new word when empty or being drained this cycle.
    assign out_free = !fifo_wvalid || fifo_wready;
    assign wr_ready = (st == StActive) && out_free;
    assign accept   = wr_valid && wr_ready;
    assign len_inc  = {{(MsgLenW - 6){1'b0}}, n, 3'b000};
    assign over     = pos - 3'd4;

    // Append the strobed bytes (byte3 first) after the held bytes and split into word + new hold.
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            bytes[i] = 8'h00;
        end
        bytes[0] = hold_data[23:16];
        bytes[1] = hold_data[15:8];
        bytes[2] = hold_data[7:0];
        pos = {1'b0, hold_cnt};
        n   = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (wr_mask[i]) begin
                bytes[pos] = wr_data[8*i +: 8];
                pos        = pos + 3'd1;
                n          = n + 3'd1;
            end
        end
        hold_cnt_next  = hold_cnt;
        hold_data_next = hold_data;
        load_full      = 1'b0;
        if (accept) begin
            if (pos >= 3'd4) begin
                load_full      = 1'b1;
                hold_cnt_next  = over[1:0];
                hold_data_next = {bytes[4], bytes[5], bytes[6]};
            end else begin
                hold_cnt_next  = pos[1:0];
                hold_data_next = {bytes[0], bytes[1], bytes[2]};
            end
        end
    end

    // Leading-ones mask for the end-of-message partial word.
    always_comb begin
        part_mask = 4'b0000;
        case (hold_cnt)
            2'd1:    part_mask = 4'b1000;
            2'd2:    part_mask = 4'b1100;
            2'd3:    part_mask = 4'b1110;
            default: part_mask = 4'b0000;
        endcase
    end

    // Next-state logic; a start request overrides everything else.
    always_comb begin
        st_next       = st;
        load_part     = 1'b0;
        msg_done_next = 1'b0;
        case (st)
            StIdle: begin
                st_next = StIdle;
            end
            StActive: begin
                if (hash_process) begin
                    st_next = StFlush;
                end
            end
            StFlush: begin
                if (out_free) begin
                    load_part = (hold_cnt != 2'd0);
                    st_next   = StDone;
                end
            end
            StDone: begin
                if (!fifo_wvalid) begin
                    msg_done_next = 1'b1;
                    st_next       = StIdle;
                end
            end
            default: st_next = StIdle;
        endcase
        if (hash_start) begin
            st_next       = StActive;
            load_part     = 1'b0;
            msg_done_next = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st <= StIdle;
        end else begin
            st <= st_next;
        end
    end

    // Hold buffer, output register, length counter and done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_cnt       <= 2'd0;
            hold_data      <= 24'h0;
            fifo_wvalid    <= 1'b0;
            fifo_wdata     <= 32'h0;
            fifo_wmask     <= 4'h0;
            message_length <= '0;
            msg_done       <= 1'b0;
        end else if (hash_start) begin
            hold_cnt       <= 2'd0;
            hold_data      <= 24'h0;
            fifo_wvalid    <= 1'b0;
            fifo_wdata     <= 32'h0;
            fifo_wmask     <= 4'h0;
            message_length <= '0;
            msg_done       <= 1'b0;
        end else begin
            msg_done <= msg_done_next;
            if (load_part) begin
                hold_cnt  <= 2'd0;
                hold_data <= 24'h0;
            end else begin
                hold_cnt  <= hold_cnt_next;
                hold_data <= hold_data_next;
            end
            if (accept) begin
                message_length <= message_length + len_inc;
            end
            if (load_full) begin
                fifo_wvalid <= 1'b1;
                fifo_wdata  <= {bytes[0], bytes[1], bytes[2], bytes[3]};
                fifo_wmask  <= 4'b1111;
            end else if (load_part) begin
                fifo_wvalid <= 1'b1;
                fifo_wdata  <= {hold_data, 8'h00};
                fifo_wmask  <= part_mask;
            end else if (fifo_wready) begin
                fifo_wvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha2_msg_pack.sv
// Testbench for sha2_msg_pack: directed and random messages checked against
// a byte-queue reference model plus an end-of-message stream comparison.
module tb_sha2_msg_pack;

    localparam int P_IDLE  = 0;
    localparam int P_ACT   = 1;
    localparam int P_FLUSH = 2;
    localparam int P_DONE  = 3;

    logic        clk;
    logic        rst_n;
    logic        hash_start;
    logic        hash_process;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        wr_ready;
    logic        fifo_wvalid;
    logic [31:0] fifo_wdata;
    logic [3:0]  fifo_wmask;
    logic        fifo_wready;
    logic [63:0] message_length;
    logic        msg_done;

    int          total = 0;
    int          bad = 0;
    int          ph = P_IDLE;
    bit          mfull = 1'b0;
    bit          mdone = 1'b0;
    logic [31:0] mword = 32'h0;
    logic [3:0]  mmask = 4'h0;
    logic [63:0] mlen = 64'h0;
    logic [7:0]  q[$];
    logic [7:0]  acc[$];
    logic [7:0]  outb[$];
    logic [35:0] got[$];
    int          done_cnt = 0;

    sha2_msg_pack #(.MsgLenW(64)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .hash_start     (hash_start),
        .hash_process   (hash_process),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_mask        (wr_mask),
        .wr_ready       (wr_ready),
        .fifo_wvalid    (fifo_wvalid),
        .fifo_wdata     (fifo_wdata),
        .fifo_wmask     (fifo_wmask),
        .fifo_wready    (fifo_wready),
        .message_length (message_length),
        .msg_done       (msg_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        ph = P_IDLE;
        mfull = 1'b0;
        mdone = 1'b0;
        mlen = 64'h0;
        q.delete();
        acc.delete();
        outb.delete();
        got.delete();
        done_cnt = 0;
    endtask

    task automatic checkOutput();
        logic exp_ready;
        exp_ready = (ph == P_ACT) && (!mfull || fifo_wready);
        chk("wr_ready", {63'h0, wr_ready}, {63'h0, exp_ready});
        chk("fifo_wvalid", {63'h0, fifo_wvalid}, {63'h0, mfull});
        if (mfull) begin
            chk("fifo_wdata", {32'h0, fifo_wdata}, {32'h0, mword});
            chk("fifo_wmask", {60'h0, fifo_wmask}, {60'h0, mmask});
        end
        chk("message_length", message_length, mlen);
        chk("msg_done", {63'h0, msg_done}, {63'h0, mdone});
        if (msg_done) done_cnt++;
    endtask

    task automatic updateModel();
        bit nfull;
        bit ndone;
        if (fifo_wvalid && fifo_wready) begin
            got.push_back({fifo_wdata, fifo_wmask});
            for (int i = 3; i >= 0; i--) begin
                if (fifo_wmask[i]) outb.push_back(fifo_wdata[8*i +: 8]);
            end
        end
        if (hash_start) begin
            modelReset();
            ph = P_ACT;
        end else begin
            nfull = (mfull && fifo_wready) ? 1'b0 : mfull;
            ndone = 1'b0;
            case (ph)
                P_ACT: begin
                    if (wr_valid && (!mfull || fifo_wready)) begin
                        for (int i = 3; i >= 0; i--) begin
                            if (wr_mask[i]) begin
                                q.push_back(wr_data[8*i +: 8]);
                                acc.push_back(wr_data[8*i +: 8]);
                            end
                        end
                        mlen = mlen + 64'(8 * $countones(wr_mask));
                        if (q.size() >= 4) begin
                            mword = {q[0], q[1], q[2], q[3]};
                            mmask = 4'hF;
                            repeat (4) void'(q.pop_front());
                            nfull = 1'b1;
                        end
                    end
                    if (hash_process) ph = P_FLUSH;
                end
                P_FLUSH: begin
                    if (!mfull || fifo_wready) begin
                        if (q.size() > 0) begin
                            mword = 32'h0;
                            mmask = 4'h0;
                            for (int i = 0; i < q.size(); i++) begin
                                mword[31-8*i -: 8] = q[i];
                                mmask[3-i] = 1'b1;
                            end
                            q.delete();
                            nfull = 1'b1;
                        end
                        ph = P_DONE;
                    end
                end
                P_DONE: begin
                    if (!mfull) begin
                        ndone = 1'b1;
                        ph = P_IDLE;
                    end
                end
                default: ;
            endcase
            mfull = nfull;
            mdone = ndone;
        end
    endtask

    // One clock: drive at the falling edge, check and model just before the rising edge.
    task automatic applyStimulus(input logic s, input logic p, input logic v,
                                 input logic [31:0] d, input logic [3:0] m, input logic r);
        hash_start   = s;
        hash_process = p;
        wr_valid     = v;
        wr_data      = d;
        wr_mask      = m;
        fifo_wready  = r;
        #4;
        checkOutput();
        updateModel();
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (!(ph == P_IDLE && !mdone) && n < 50) begin
            applyStimulus(0, 0, 0, 32'h0, 4'h0, 1);
            n++;
        end
        chk("drain_timeout", {63'h0, (ph == P_IDLE)}, 64'h1);
    endtask

    task automatic checkStream();
        chk("stream_len", 64'(outb.size()), 64'(acc.size()));
        for (int i = 0; i < acc.size() && i < outb.size(); i++) begin
            chk("stream_byte", {56'h0, outb[i]}, {56'h0, acc[i]});
        end
        chk("done_pulses", 64'(done_cnt), 64'h1);
    endtask

    initial begin
        rst_n = 1'b0;
        hash_start = 0; hash_process = 0; wr_valid = 0;
        wr_data = 32'h0; wr_mask = 4'h0; fifo_wready = 0;
        modelReset();
        #3;
        chk("rst_wr_ready", {63'h0, wr_ready}, 64'h0);
        chk("rst_fifo_wvalid", {63'h0, fifo_wvalid}, 64'h0);
        chk("rst_fifo_wdata", {32'h0, fifo_wdata}, 64'h0);
        chk("rst_fifo_wmask", {60'h0, fifo_wmask}, 64'h0);
        chk("rst_length", message_length, 64'h0);
        chk("rst_msg_done", {63'h0, msg_done}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 1);

        // Aligned message
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 1);
        applyStimulus(0, 0, 1, 32'h61626364, 4'hF, 1);
        applyStimulus(0, 0, 1, 32'h65666768, 4'hF, 1);
        applyStimulus(0, 1, 0, 32'h0, 4'h0, 1);
        drain();
        checkStream();
        chk("aligned_len", message_length, 64'd64);
        chk("aligned_pushes", 64'(got.size()), 64'd2);
        chk("aligned_w0", {28'h0, got[0]}, {28'h0, 32'h61626364, 4'hF});
        chk("aligned_w1", {28'h0, got[1]}, {28'h0, 32'h65666768, 4'hF});

        // hash_process in Idle is ignored
        applyStimulus(0, 1, 1, 32'h12345678, 4'hF, 1);
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 1);

        // Sparse strobes, including a mask-0 write
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 1);
        applyStimulus(0, 0, 1, 32'hAABBCCDD, 4'b1010, 1);
        applyStimulus(0, 0, 1, 32'hDEADBEEF, 4'b0000, 1);
        applyStimulus(0, 0, 1, 32'h11223344, 4'b0101, 1);
        applyStimulus(0, 0, 1, 32'h55667788, 4'b1000, 1);
        applyStimulus(0, 1, 0, 32'h0, 4'h0, 1);
        drain();
        checkStream();
        chk("sparse_len", message_length, 64'd40);
        chk("sparse_w0", {28'h0, got[0]}, {28'h0, 32'hAACC2244, 4'hF});
        chk("sparse_w1", {28'h0, got[1]}, {28'h0, 32'h55000000, 4'b1000});

        // Partial flush width
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 1);
        applyStimulus(0, 0, 1, 32'h616263FF, 4'b1110, 1);
        applyStimulus(0, 1, 0, 32'h0, 4'h0, 1);
        drain();
        checkStream();
        chk("partial_len", message_length, 64'd24);
        chk("partial_w0", {28'h0, got[0]}, {28'h0, 32'h61626300, 4'b1110});

        // Final write coincident with hash_process
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 1);
        applyStimulus(0, 1, 1, 32'h11223344, 4'b0111, 1);
        drain();
        checkStream();
        chk("coinc_w0", {28'h0, got[0]}, {28'h0, 32'h22334400, 4'b1110});

        // Backpressure for 5 cycles, then release
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, $urandom, 4'hF, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, $urandom, 4'hF, 1);
        applyStimulus(0, 1, 0, 32'h0, 4'h0, 1);
        drain();
        checkStream();

        // Restart with a full output register and two held bytes
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 1);
        applyStimulus(0, 0, 1, 32'hA1A2A3A4, 4'b1100, 0);
        applyStimulus(0, 0, 1, 32'hB1B2B3B4, 4'hF, 0);
        applyStimulus(1, 1, 1, 32'hC1C2C3C4, 4'hF, 1);
        chk("restart_wvalid", {63'h0, fifo_wvalid}, 64'h0);
        chk("restart_len", message_length, 64'h0);
        applyStimulus(0, 0, 1, 32'h01020304, 4'hF, 1);
        applyStimulus(0, 1, 0, 32'h0, 4'h0, 1);
        drain();
        checkStream();
        chk("restart_w0", {28'h0, got[0]}, {28'h0, 32'h01020304, 4'hF});

        // Async reset mid-message
        applyStimulus(1, 0, 0, 32'h0, 4'h0, 1);
        applyStimulus(0, 0, 1, 32'hCAFEF00D, 4'hF, 0);
        applyStimulus(0, 0, 1, 32'h0BADBEEF, 4'b1100, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wvalid", {63'h0, fifo_wvalid}, 64'h0);
        chk("arst_len", message_length, 64'h0);
        chk("arst_wr_ready", {63'h0, wr_ready}, 64'h0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 4'h0, 1);

        // Random messages
        for (int k = 0; k < 8; k++) begin
            int len;
            len = 5 + int'($urandom_range(0, 15));
            applyStimulus(1, 0, 0, 32'h0, 4'h0, 1);
            for (int c = 0; c < len; c++) begin
                applyStimulus(0, (c == len - 1), ($urandom_range(0, 3) != 0), $urandom,
                              4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            end
            drain();
            checkStream();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha2_msg_pack.md
Name: sha2_msg_pack

Overview:
- Producer side of the SHA-2 message FIFO; feeds the padding stage its words and byte masks.
- Accepts 32-bit register-bus message writes with arbitrary byte strobes and compacts the valid bytes MSB-first into a contiguous stream.
- Pushes full words (mask 4'b1111) to the FIFO, then one left-aligned partial word at end of message.
- Maintains the running message length in bits, which feeds message_length of the padding stage.

Parameters:
- MsgLenW, 64, width of the message_length counter in bits; length wraps modulo 2^MsgLenW.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- hash_start  input  1  single-cycle pulse: start new message, clear all state
- hash_process  input  1  single-cycle pulse: end of message, flush partial bytes
- wr_valid  input  1  message write request
- wr_data  input  32  write data; byte3 = bits[31:24] is the first byte in order
- wr_mask  input  4  byte strobes, any pattern including 0
- wr_ready  output  1  write accepted when wr_valid && wr_ready
- fifo_wvalid  output  1  FIFO push request
- fifo_wdata  output  32  packed word; valid bytes are left-aligned (MSB first)
- fifo_wmask  output  4  per-byte valid for fifo_wdata: 4'b1111, 1110, 1100 or 1000
- fifo_wready  input  1  FIFO can accept
- message_length  output  MsgLenW  accepted bytes times 8
- msg_done  output  1  one-cycle pulse after the final word is handed to the FIFO

Behaviour:
- Reset values:
  - st=Idle, hold_cnt=0, hold_data=0.
  - fifo_wvalid=0, fifo_wdata=0, fifo_wmask=0.
  - message_length=0, msg_done=0, wr_ready=0.
- Output register:
  - Single entry. Once fifo_wvalid=1, data and mask are held until fifo_wready.
  - Only hash_start may drop the entry.
- wr_ready = (st==Active) && (!fifo_wvalid || fifo_wready). This is a combinational path from fifo_wready.
- Compaction on an accepted write:
  - n = popcount(wr_mask).
  - The selected bytes are taken in order byte3..byte0 and appended after the hold_cnt held bytes (hold_cnt 0..3).
  - If hold_cnt+n >= 4: the first 4 bytes load the output register with mask 4'b1111 next cycle; the remaining hold_cnt+n-4 bytes become the new hold.
  - Otherwise there is no push and hold_cnt grows.
- message_length += 8*n on every accepted write, including n=0 (adds 0). Updates the cycle after acceptance.
- Push latency: 1 cycle from acceptance to fifo_wvalid.
- States:
  - Idle: wr_ready=0. On hash_start, go to Active.
  - Active: accept writes. On hash_process, go to Flush. A write accepted in the same cycle as hash_process is packed first.
  - Flush: wr_ready=0. Wait until the output register is empty or fifo_wready.
    - If hold_cnt>0: load hold bytes left-aligned, zero-filled, mask = hold_cnt leading ones; clear hold; go to Done.
    - If hold_cnt==0: go to Done directly, with no partial word.
  - Done: wait until the output register is empty. Then pulse msg_done and go to Idle.
- hash_start in any state: next cycle st=Active, hold cleared, output register cleared (fifo_wvalid=0), message_length=0, and any write in that cycle dropped. hash_start wins over a simultaneous hash_process.
- hash_process is ignored outside Active.
- Pad bytes of a partial word and unused hold bytes are always driven 0.
- message_length holds its value through Idle until the next hash_start. It wraps silently at 2^MsgLenW.
- Async reset mid-message returns to the reset values immediately; the FIFO contents are owned externally.

Test Plan:
- Aligned message:
  - Stimulus: hash_start; writes 0x61626364 and 0x65666768 with mask F, fifo_wready=1; hash_process.
  - Response: two pushes with mask F in order, no partial word, message_length=64, msg_done pulses once.
- Sparse strobes:
  - Stimulus: writes 0xAABBCCDD mask 1010, 0x11223344 mask 0101, 0x55667788 mask 1000; hash_process.
  - Response: push 0xAACC2244 mask F; flush 0x55000000 mask 1000; message_length=40.
- Partial flush width:
  - Stimulus: write mask 1110 data 0x616263FF; hash_process.
  - Response: single push 0x61626300 mask 1110, message_length=24.
- Backpressure:
  - Stimulus: fifo_wready=0 for 5 cycles while wr_valid=1.
  - Response: wr_ready=0 after the first push; fifo_wdata and fifo_wmask stable; no bytes lost or duplicated after release.
- Restart:
  - Stimulus: hash_start while the output register is full and hold_cnt=2.
  - Response: fifo_wvalid=0 and message_length=0 next cycle; the new message packs from byte 0.
- Corner cases:
  - Mask 0 write is accepted with no length change.
  - hash_process with hold_cnt=0 emits no partial word.
  - hash_process coincident with a final write packs that write's bytes.
